// File: rtl/dmem_responder.sv
// Single-outstanding data memory responder with fixed response latency.
// Checks access alignment and store strobes; errored requests never touch the array.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [2:0] CNT_INIT =
    (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;

  logic                  wr_q;
  logic [1:0]            size_q;
  logic [DEPTH_LOG2+1:0] addr_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           wdata_q;

  logic [31:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic accept;
  logic err_c;

  // Upper address bits alias onto the array.
  logic unused_addr;
  assign unused_addr = ^addr[31:DEPTH_LOG2+2];

  assign idx     = addr_q[DEPTH_LOG2+1:2];
  assign addr_ok = resetn && (state == IDLE);
  assign data_ok = (state == RESP);
  assign accept  = req && addr_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wstrb_q <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        wr_q    <= wr;
        size_q  <= size;
        addr_q  <= addr[DEPTH_LOG2+1:0];
        wstrb_q <= wstrb;
        wdata_q <= wdata;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (1'b1)
      (state == IDLE): begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nx = RESP;
          end else begin
            state_nx = BUSY;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      (state == BUSY): begin
        if (cnt == 3'd0) state_nx = RESP;
        else             cnt_nx   = cnt - 3'd1;
      end
      (state == RESP): state_nx = IDLE;
      default:         state_nx = IDLE;
    endcase
  end

  always_comb begin
    err_c = 1'b0;
    case (size_q)
      2'd0: err_c = wr_q &&
              (wstrb_q != (4'b0001 << addr_q[1:0]));
      2'd1: err_c = addr_q[0] ||
              (wr_q && (wstrb_q !=
                (addr_q[1] ? 4'b1100 : 4'b0011)));
      2'd2: err_c = (addr_q[1:0] != 2'b00) ||
              (wr_q && (wstrb_q != 4'b1111));
      default: err_c = 1'b1;
    endcase
  end

  assign err   = data_ok && err_c;
  assign rdata = (data_ok && !wr_q && !err_c) ? mem[idx] : 32'd0;

  // Commit on the edge that ends RESP, unless reset cancels it.
  always_ff @(posedge clk) begin
    if (resetn && data_ok && wr_q && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 main instance,
// plus LATENCY=1 and LATENCY=7 instances for latency checks.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [31:0] addr = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic        addr_ok, data_ok, err;
  logic [31:0] rdata;

  logic        req_1 = 1'b0, req_7 = 1'b0;
  logic        addr_ok_1, data_ok_1, err_1;
  logic        addr_ok_7, data_ok_7, err_7;
  logic [31:0] rdata_1, rdata_7;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr),
    .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .err(err)
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_lat1 (
    .clk(clk), .resetn(resetn), .req(req_1), .wr(wr),
    .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok_1), .data_ok(data_ok_1),
    .rdata(rdata_1), .err(err_1)
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(7)) u_lat7 (
    .clk(clk), .resetn(resetn), .req(req_7), .wr(wr),
    .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok_7), .data_ok(data_ok_7),
    .rdata(rdata_7), .err(err_7)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input string tag,
                      input logic w, input logic [1:0] s,
                      input logic [31:0] a, input logic [3:0] st,
                      input logic [31:0] d,
                      input logic [31:0] exp_rdata,
                      input logic exp_err);
    @(negedge clk);
    chk({tag, "_addr_ok"}, 32'(addr_ok), 32'd1);
    req = 1'b1; wr = w; size = s; addr = a; wstrb = st; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      if (k > 1) @(negedge clk);
      chk({tag, "_data_ok"}, 32'(data_ok), 32'(k == LAT));
      if (k < LAT) chk({tag, "_rdata_idle"}, rdata, 32'd0);
    end
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_addr_ok", 32'(addr_ok), 32'd0);
    chk("rst_data_ok", 32'(data_ok), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rel_addr_ok", 32'(addr_ok), 32'd1);

    xfer("st_word", 1, 2'd2, 32'h40, 4'hF, 32'h11223344, 32'd0, 0);
    xfer("ld_word", 0, 2'd2, 32'h40, 4'h0, 32'd0, 32'h11223344, 0);
    xfer("st_byte", 1, 2'd0, 32'h41, 4'b0010, 32'hAAAAAAAA, 32'd0, 0);
    xfer("ld_byte", 0, 2'd2, 32'h40, 4'h0, 32'd0, 32'h1122AA44, 0);
    xfer("st_half_bad", 1, 2'd1, 32'h42, 4'b0011, 32'h55555555,
         32'd0, 1);
    xfer("ld_after_bad", 0, 2'd2, 32'h40, 4'hF, 32'd0, 32'h1122AA44, 0);
    xfer("ld_misalign", 0, 2'd2, 32'h41, 4'hF, 32'd0, 32'd0, 1);
    xfer("ld_size3", 0, 2'd3, 32'h40, 4'h0, 32'd0, 32'd0, 1);
    xfer("st_byte_bad", 1, 2'd0, 32'h40, 4'b0010, 32'h99999999,
         32'd0, 1);
    xfer("st_half", 1, 2'd1, 32'h42, 4'b1100, 32'h77667766, 32'd0, 0);
    xfer("ld_alias", 0, 2'd2, 32'h1040, 4'h0, 32'd0, 32'h7766AA44, 0);

    // req held high: accept every LAT+1 cycles
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h40; wstrb = 4'h0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_addr_ok", 32'(addr_ok), 32'(i % 3 == 0));
      chk("hold_data_ok", 32'(data_ok), 32'(i % 3 == 2));
      if (i % 3 == 2) chk("hold_rdata", rdata, 32'h7766AA44);
    end
    req = 1'b0;

    // reset during BUSY cancels the store
    xfer("st_prior", 1, 2'd2, 32'h80, 4'hF, 32'h0BADF00D, 32'd0, 0);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h80;
    wstrb = 4'hF; wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mid_rst_data_ok", 32'(data_ok), 32'd0);
    chk("mid_rst_addr_ok", 32'(addr_ok), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_data_ok", 32'(data_ok), 32'd0);
    end
    xfer("ld_prior", 0, 2'd2, 32'h80, 4'h0, 32'd0, 32'h0BADF00D, 0);

    // latency 1 and 7 instances
    wr = 1'b0; size = 2'd2; addr = 32'h0; wstrb = 4'h0;
    @(negedge clk);
    chk("lat1_addr_ok", 32'(addr_ok_1), 32'd1);
    req_1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_1 = 1'b0;
    n = 1;
    while (!data_ok_1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("lat1_cycles", 32'(n), 32'd1);

    @(negedge clk);
    chk("lat7_addr_ok", 32'(addr_ok_7), 32'd1);
    req_7 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_7 = 1'b0;
    n = 1;
    while (!data_ok_7 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("lat7_cycles", 32'(n), 32'd7);
    @(negedge clk);
    chk("lat7_done", 32'(data_ok_7), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter: DEPTH_LOG2, 10, log2 of word count of internal data array.
REQ-002 SHALL have parameter: LATENCY, 2, cycles from request accept to data_ok; legal range 1..7.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: req  input  1  initiator request valid.
REQ-006 SHALL have port: wr  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal.
REQ-008 SHALL have port: addr  input  32  byte address.
REQ-009 SHALL have port: wstrb  input  4  byte-lane write enables, lane i = wdata[8i+7:8i].
REQ-010 SHALL have port: wdata  input  32  store data, already lane-replicated by initiator.
REQ-011 SHALL have port: addr_ok  output  1  request accepted this cycle when req=1.
REQ-012 SHALL have port: data_ok  output  1  one-cycle response strobe.
REQ-013 SHALL have port: rdata  output  32  full aligned word for loads; valid only while data_ok=1.
REQ-014 SHALL have port: err  output  1  alignment/strobe error flag; valid only while data_ok=1.

Function
REQ-015 SHALL implement FSM IDLE, BUSY, RESP; addr_ok=1 only in IDLE; data_ok=1 only in RESP.
REQ-016 SHALL accept on req&&addr_ok, capturing wr, size, addr, wstrb, wdata in that edge.
REQ-017 SHALL, on accept, go to RESP if LATENCY=1, else BUSY with a down-counter loaded with LATENCY-2.
REQ-018 SHALL, in BUSY, decrement the counter each cycle and go to RESP when counter is 0; data_ok asserts exactly LATENCY cycles after the accept edge.
REQ-019 SHALL, from RESP, always return to IDLE next cycle; one outstanding request max; no accept during BUSY or RESP.
REQ-020 SHALL index the array with addr[DEPTH_LOG2+1:2]; higher address bits ignored (aliasing).
REQ-021 SHALL flag error when: size=3; size=0 and wstrb != one-hot lane addr[1:0] (stores only); size=1 and addr[0]=1, or store wstrb != 0011 (addr[1]=0) / 1100 (addr[1]=1); size=2 and addr[1:0]!=0, or store wstrb != 1111.
REQ-022 SHALL, for loads, check only the alignment rules of REQ-021 and ignore wstrb.
REQ-023 SHALL, for a legal load, drive rdata with the whole array word; lane extraction/sign extension is the initiator's job.
REQ-024 SHALL, for a legal store, update only bytes whose wstrb bit is 1, at the rising edge ending the RESP cycle; rdata=0 during store responses.
REQ-025 SHALL, on error, leave the array unchanged, drive rdata=0 and err=1 with data_ok.
REQ-026 SHALL return the updated data for a load accepted after a store's data_ok (read-after-write coherent).
REQ-027 SHALL hold rdata=0 and err=0 whenever data_ok=0.

Reset
REQ-028 SHALL, on resetn=0, asynchronously force state IDLE, counter 0, addr_ok=1 once released (0 while held), data_ok=0, rdata=0, err=0.
REQ-029 SHALL, on reset asserted before the edge ending RESP, discard the pending request with no array write and no data_ok.
REQ-030 SHALL NOT reset array contents.

Verification
REQ-031 SHALL cover: LATENCY=2, store word 0x11223344 to 0x40 wstrb 1111, then load 0x40 -> data_ok 2 cycles after each accept, rdata=0x11223344, err=0.
REQ-032 SHALL cover: store byte 0xAA replicated to 0x41 wstrb 0010 over word 0x11223344 -> load 0x40 returns 0x1122AA44.
REQ-033 SHALL cover: store half to 0x42 wstrb 0011 -> err=1 with data_ok, word at 0x40 unchanged; load word at 0x41 -> err=1, rdata=0.
REQ-034 SHALL cover: req held high continuously -> accepts only in IDLE, data_ok spacing LATENCY+1 cycles apart, addr_ok=0 in BUSY/RESP.
REQ-035 SHALL cover: resetn pulsed low during BUSY of store 0xDEADBEEF to 0x80 -> no data_ok, subsequent load 0x80 returns prior contents.
REQ-036 SHALL cover: LATENCY=1 and LATENCY=7 builds -> data_ok exactly 1 and 7 cycles after accept.
